edit_sequencer: RTL and testbench

EDIT_SEQUENCER -- requirements
Module: edit_sequencer

---
 rtl/edit_sequencer.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_edit_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edit_sequencer.sv
// ============================================================================
// edit_sequencer
// ----------------------------------------------------------------------------
// Purpose:
//   Front end for a clock/calendar setting panel. Three raw push buttons
//   (change, increase, decrease) are synchronized and debounced. The change
//   button walks the edit field RUN -> 1 -> 2 -> 3 -> RUN. The increase and
//   decrease buttons produce one-clock strobes for the counter datapath while
//   an edit field is selected. An inactivity timer based on tick_1s drops
//   back to RUN when the operator walks away.
//
// Optional feature:
//   EDIT_SEQUENCER_AUTO_REPEAT_EN
//     defined   : a single held inc/dec button auto-repeats, first repeat
//                 REPEAT_DLY cycles after the initial pulse, then every
//                 REPEAT_PER cycles.
//     undefined : one pulse per debounced press; no repeat counters exist.
//
// Parameters:
//   DEB_CYCLES  cycles a synchronized level must disagree before the
//               debounced level follows it
//   REPEAT_DLY  hold time before the first auto-repeat pulse
//   REPEAT_PER  spacing of later auto-repeat pulses
//   TIMEOUT_S   tick_1s strobes without activity before editing aborts
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous reset, active low
//   tick_1s        one-clock 1 Hz strobe
//   sw_mode        0 = time fields, 1 = date fields
//   butt_change    raw change button, 0 = pressed
//   butt_increase  raw increase button, 0 = pressed
//   butt_decrease  raw decrease button, 0 = pressed
//   field          0 = RUN, 1..3 = selected edit field
//   inc_pulse      one-clock increment strobe
//   dec_pulse      one-clock decrement strobe
//   led_field      one-hot field indicator, bit n-1 for field n
//   edit_active    high whenever field is not RUN
// ============================================================================
module edit_sequencer #(
    parameter int DEB_CYCLES = 250_000,
    parameter int REPEAT_DLY = 25_000_000,
    parameter int REPEAT_PER = 6_250_000,
    parameter int TIMEOUT_S  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1s,
    input  logic       sw_mode,
    input  logic       butt_change,
    input  logic       butt_increase,
    input  logic       butt_decrease,
    output logic [1:0] field,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic [2:0] led_field,
    output logic       edit_active
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam int TW = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S + 1) : 1;

    // Button index inside the packed vectors below.
    localparam int B_CHG = 0;
    localparam int B_INC = 1;
    localparam int B_DEC = 2;

    logic [2:0]    raw_btn;
    logic [2:0]    sync_a;
    logic [2:0]    sync_b;
    logic [2:0]    deb;
    logic [2:0]    deb_d;
    logic [DW-1:0] deb_cnt [3];

    logic [2:0]    pressed;
    logic [2:0]    press_edge;

    logic          sw_mode_d;
    logic          mode_chg;
    logic          in_edit;
    logic          timeout;
    logic [TW-1:0] timer;
    logic [1:0]    field_nxt;
    logic          field_chg;
    logic          clr_rep;
    logic [2:0]    led_nxt;

    logic          blk_inc;
    logic          blk_dec;
    logic          eff_inc;
    logic          eff_dec;
    logic          eff_inc_d;
    logic          eff_dec_d;
    logic          rise_inc;
    logic          rise_dec;
    logic          fire_inc;
    logic          fire_dec;

    assign raw_btn = {butt_decrease, butt_increase, butt_change};

    // Two-flop synchronizer followed by a per-button debouncer. The counter
    // only advances while the synchronized level disagrees with the
    // debounced level; any agreeing sample throws the partial count away.
    // deb_d keeps last cycle's debounced level so a press edge can be seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 3'b111;
            sync_b <= 3'b111;
            deb    <= 3'b111;
            deb_d  <= 3'b111;
            for (int b = 0; b < 3; b++) begin
                deb_cnt[b] <= '0;
            end
        end else begin
            sync_a <= raw_btn;
            sync_b <= sync_a;
            deb_d  <= deb;
            for (int b = 0; b < 3; b++) begin
                if (sync_b[b] == deb[b]) begin
                    deb_cnt[b] <= '0;
                end else if (deb_cnt[b] >= DW'(DEB_CYCLES - 1)) begin
                    deb[b]     <= sync_b[b];
                    deb_cnt[b] <= '0;
                end else begin
                    deb_cnt[b] <= deb_cnt[b] + 1'b1;
                end
            end
        end
    end

    // Press edges are high for exactly the one cycle in which the debounced
    // level has just gone low. The effective inc/dec levels fold in the
    // "both held means neither" rule, the post-field-change lockout and the
    // RUN suppression, so a rising effective level is a fresh press.
    always_comb begin
        pressed    = ~deb;
        press_edge = ~deb & deb_d;
        mode_chg   = sw_mode ^ sw_mode_d;
        in_edit    = (field != 2'd0);
        timeout    = tick_1s && in_edit && (timer >= TW'(TIMEOUT_S - 1));
        eff_inc    = pressed[B_INC] && !pressed[B_DEC] && !blk_inc && in_edit;
        eff_dec    = pressed[B_DEC] && !pressed[B_INC] && !blk_dec && in_edit;
        rise_inc   = eff_inc && !eff_inc_d;
        rise_dec   = eff_dec && !eff_dec_d;
    end

    // Next field. A mode toggle while editing wins because the fields of the
    // other mode are meaningless; a change press outranks the inactivity
    // timeout, and the 2-bit add wraps 3 back to RUN on its own.
    always_comb begin
        field_nxt = field;
        if (mode_chg && in_edit) begin
            field_nxt = 2'd0;
        end else if (press_edge[B_CHG]) begin
            field_nxt = field + 2'd1;
        end else if (timeout) begin
            field_nxt = 2'd0;
        end
        field_chg = (field_nxt != field);
        clr_rep   = field_chg || mode_chg;
        case (field_nxt)
            2'd1:    led_nxt = 3'b001;
            2'd2:    led_nxt = 3'b010;
            2'd3:    led_nxt = 3'b100;
            default: led_nxt = 3'b000;
        endcase
    end

    // Field register with its decoded indicators. The indicators decode the
    // next field so they change on the same edge as field itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field       <= 2'd0;
            led_field   <= 3'b000;
            edit_active <= 1'b0;
            sw_mode_d   <= 1'b0;
        end else begin
            field       <= field_nxt;
            led_field   <= led_nxt;
            edit_active <= (field_nxt != 2'd0);
            sw_mode_d   <= sw_mode;
        end
    end

    // Inactivity timer. Any press or field change restarts it; otherwise it
    // counts seconds while editing. Reaching the limit causes a field change
    // through field_nxt, which in turn clears the timer here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if ((|press_edge) || field_chg) begin
            timer <= '0;
        end else if (tick_1s && in_edit && (timer < TW'(TIMEOUT_S))) begin
            timer <= timer + 1'b1;
        end
    end

    // Lockout flags. A button still held when the field or mode changes is
    // ignored until it is released, so an adjustment never leaks into the
    // newly selected field. The effective-level history is kept alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_inc   <= 1'b0;
            blk_dec   <= 1'b0;
            eff_inc_d <= 1'b0;
            eff_dec_d <= 1'b0;
        end else begin
            if (!pressed[B_INC]) begin
                blk_inc <= 1'b0;
            end else if (clr_rep) begin
                blk_inc <= 1'b1;
            end
            if (!pressed[B_DEC]) begin
                blk_dec <= 1'b0;
            end else if (clr_rep) begin
                blk_dec <= 1'b1;
            end
            eff_inc_d <= eff_inc;
            eff_dec_d <= eff_dec;
        end
    end

`ifdef EDIT_SEQUENCER_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX + 1) : 1;

    logic [RW-1:0] rep_cnt_inc;
    logic [RW-1:0] rep_cnt_dec;
    logic          rep_per_inc;
    logic          rep_per_dec;

    // A repeat fires once the hold counter reaches the initial delay, and
    // afterwards every time it reaches the period. The counter reads 1 in
    // the cycle the previous pulse appears, so the spacing is exact.
    always_comb begin
        fire_inc = eff_inc && eff_inc_d &&
                   (rep_per_inc ? (rep_cnt_inc == RW'(REPEAT_PER))
                                : (rep_cnt_inc == RW'(REPEAT_DLY)));
        fire_dec = eff_dec && eff_dec_d &&
                   (rep_per_dec ? (rep_cnt_dec == RW'(REPEAT_PER))
                                : (rep_cnt_dec == RW'(REPEAT_DLY)));
    end

    // Hold counters. They sit at zero whenever the effective level is low
    // (released, both held, locked out) and on any field or mode change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_inc <= '0;
            rep_cnt_dec <= '0;
            rep_per_inc <= 1'b0;
            rep_per_dec <= 1'b0;
        end else begin
            if (clr_rep || !eff_inc) begin
                rep_cnt_inc <= '0;
                rep_per_inc <= 1'b0;
            end else if (fire_inc) begin
                rep_cnt_inc <= RW'(1);
                rep_per_inc <= 1'b1;
            end else if (rep_cnt_inc != RW'(RMAX)) begin
                rep_cnt_inc <= rep_cnt_inc + 1'b1;
            end
            if (clr_rep || !eff_dec) begin
                rep_cnt_dec <= '0;
                rep_per_dec <= 1'b0;
            end else if (fire_dec) begin
                rep_cnt_dec <= RW'(1);
                rep_per_dec <= 1'b1;
            end else if (rep_cnt_dec != RW'(RMAX)) begin
                rep_cnt_dec <= rep_cnt_dec + 1'b1;
            end
        end
    end
`else
    // Without auto-repeat only the fresh-press edge produces a pulse. The
    // repeat parameters are still referenced so the interface stays the same
    // in both builds; a nonsensical setting simply has nothing to act on.
    always_comb begin
        fire_inc = 1'b0;
        fire_dec = 1'b0;
    end

    if (REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_repeat_cfg_unused
    end
`endif

    // Output strobes. Pulses are dropped on a field or mode change edge so
    // none is ever seen together with a different field than it was meant
    // for. eff_inc and eff_dec are mutually exclusive, so are the strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_pulse <= 1'b0;
            dec_pulse <= 1'b0;
        end else begin
            inc_pulse <= !clr_rep && (rise_inc || fire_inc);
            dec_pulse <= !clr_rep && (rise_dec || fire_dec);
        end
    end

endmodule

// File: tb/tb_edit_sequencer.sv
// ============================================================================
// tb_edit_sequencer
// ----------------------------------------------------------------------------
// Self-checking bench for edit_sequencer with small parameters
// (DEB_CYCLES=4, REPEAT_DLY=20, REPEAT_PER=5, TIMEOUT_S=3). Press and hold
// lengths are randomized; expected pulse times come from the latency rule
// (2 sync + DEB_CYCLES debounce + 1 output register) and the repeat rule.
// ============================================================================
module tb_edit_sequencer;

    localparam int DEB  = 4;
    localparam int RDLY = 20;
    localparam int RPER = 5;
    localparam int TOUT = 3;
    // Edges from driving a raw press until the strobe / field update shows.
    localparam int LAT  = 2 + DEB + 1;

    logic       clk;
    logic       rst_n;
    logic       tick_1s;
    logic       sw_mode;
    logic       butt_change;
    logic       butt_increase;
    logic       butt_decrease;
    logic [1:0] field;
    logic       inc_pulse;
    logic       dec_pulse;
    logic [2:0] led_field;
    logic       edit_active;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int inc_q[$];
    int dec_q[$];
    int exp_q[$];
    int both_err = 0;
    int run_err  = 0;
    int led_err  = 0;

    edit_sequencer #(
        .DEB_CYCLES(DEB),
        .REPEAT_DLY(RDLY),
        .REPEAT_PER(RPER),
        .TIMEOUT_S (TOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_1s      (tick_1s),
        .sw_mode      (sw_mode),
        .butt_change  (butt_change),
        .butt_increase(butt_increase),
        .butt_decrease(butt_decrease),
        .field        (field),
        .inc_pulse    (inc_pulse),
        .dec_pulse    (dec_pulse),
        .led_field    (led_field),
        .edit_active  (edit_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] onehot(input logic [1:0] f);
        logic [2:0] r;
        r = 3'b000;
        if (f != 2'd0) r[f - 2'd1] = 1'b1;
        return r;
    endfunction

    // Continuous observation: record strobe times and note rule breaches.
    always @(negedge clk) begin
        if (inc_pulse === 1'b1) inc_q.push_back(cyc);
        if (dec_pulse === 1'b1) dec_q.push_back(cyc);
        if (inc_pulse === 1'b1 && dec_pulse === 1'b1) both_err++;
        if ((inc_pulse === 1'b1 || dec_pulse === 1'b1) && field === 2'd0) run_err++;
        if (led_field !== onehot(field) || edit_active !== (field != 2'd0)) led_err++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic set_btn(input int which, input logic val);
        case (which)
            0:       butt_change   = val;
            1:       butt_increase = val;
            default: butt_decrease = val;
        endcase
    endtask

    task automatic drive_press(input int which, input int hold, input int gap, output int start);
        set_btn(which, 1'b0);
        start = cyc;
        repeat (hold) @(negedge clk);
        set_btn(which, 1'b1);
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_tick();
        tick_1s = 1'b1;
        @(negedge clk);
        tick_1s = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Expected strobe times for one held button pressed at 'start'.
    task automatic build_exp(input int start, input int hold);
        int t;
        int last;
        exp_q.delete();
        exp_q.push_back(start + LAT);
        last = start + hold + LAT - 1;
`ifdef EDIT_SEQUENCER_AUTO_REPEAT_EN
        t = start + LAT + RDLY;
        while (t <= last) begin
            exp_q.push_back(t);
            t += RPER;
        end
`else
        t = last;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (field !== 2'd0) begin errors++; $display("[TB] FAIL reset_field: got %0d expected 0", field); end
        checks++; if (led_field !== 3'b000) begin errors++; $display("[TB] FAIL reset_led: got %b expected 000", led_field); end
        checks++; if (edit_active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active: got %b expected 0", edit_active); end
        checks++; if ({inc_pulse, dec_pulse} !== 2'b00) begin errors++; $display("[TB] FAIL reset_pulses: got %b expected 00", {inc_pulse, dec_pulse}); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (field !== 2'd0) begin errors++; $display("[TB] FAIL post_reset_field: got %0d expected 0", field); end
    endtask

    task automatic test_change_cycle();
        logic [1:0] exp_f;
        int hold;
        for (int k = 0; k < 4; k++) begin
            exp_f = 2'(k + 1);
            hold  = 30 + int'($urandom_range(0, 10));
            butt_change = 1'b0;
            repeat (LAT - 1) @(negedge clk);
            checks++; if (field !== 2'(k)) begin errors++; $display("[TB] FAIL change_early_%0d: got %0d expected %0d", k, field, k); end
            @(negedge clk);
            checks++; if (field !== exp_f) begin errors++; $display("[TB] FAIL change_field_%0d: got %0d expected %0d", k, field, exp_f); end
            checks++; if (led_field !== onehot(exp_f)) begin errors++; $display("[TB] FAIL change_led_%0d: got %b expected %b", k, led_field, onehot(exp_f)); end
            repeat (hold - LAT) @(negedge clk);
            butt_change = 1'b1;
            repeat (30 + $urandom_range(0, 10)) @(negedge clk);
            checks++; if (field !== exp_f) begin errors++; $display("[TB] FAIL change_hold_%0d: got %0d expected %0d", k, field, exp_f); end
        end
    endtask

    task automatic test_glitch_and_press();
        int st;
        int hold;
        drive_press(0, 30, 30, st);
        checks++; if (field !== 2'd1) begin errors++; $display("[TB] FAIL glitch_setup: got %0d expected 1", field); end
        inc_q.delete();
        for (int g = 0; g < 3; g++) begin
            butt_increase = 1'b0;
            repeat (1 + $urandom_range(0, 2)) @(negedge clk);
            butt_increase = 1'b1;
            repeat (12) @(negedge clk);
        end
        checks++; if (inc_q.size() != 0) begin errors++; $display("[TB] FAIL glitch_pulses: got %0d expected 0", inc_q.size()); end
        hold = 25 + int'($urandom_range(0, 20));
        drive_press(1, hold, 30, st);
        build_exp(st, hold);
        checks++;
        if (inc_q.size() != exp_q.size()) begin
            errors++; $display("[TB] FAIL press_count: got %0d expected %0d", inc_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++; if (inc_q[i] != exp_q[i]) begin errors++; $display("[TB] FAIL press_time_%0d: got %0d expected %0d", i, inc_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_repeat();
        int st;
        int hold;
        drive_press(0, 30, 30, st);
        checks++; if (field !== 2'd2) begin errors++; $display("[TB] FAIL repeat_setup: got %0d expected 2", field); end
        for (int r = 0; r < 2; r++) begin
            hold = (r == 0) ? 60 : 40 + int'($urandom_range(0, 30));
            inc_q.delete();
            dec_q.delete();
            drive_press(2, hold, 30, st);
            build_exp(st, hold);
            checks++;
            if (dec_q.size() != exp_q.size()) begin
                errors++; $display("[TB] FAIL repeat_count_%0d: got %0d expected %0d", r, dec_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    checks++; if (dec_q[i] != exp_q[i]) begin errors++; $display("[TB] FAIL repeat_time_%0d_%0d: got %0d expected %0d", r, i, dec_q[i], exp_q[i]); end
                end
            end
            checks++; if (inc_q.size() != 0) begin errors++; $display("[TB] FAIL repeat_no_inc_%0d: got %0d expected 0", r, inc_q.size()); end
        end
    endtask

    // Change press whose edge lands in the same cycle as a tick strobe.
    task automatic change_with_tick();
        butt_change = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        tick_1s = 1'b1;
        @(negedge clk);
        tick_1s = 1'b0;
        repeat (23) @(negedge clk);
        butt_change = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_timeout();
        int st;
        drive_press(0, 30, 30, st);
        pulse_tick();
        pulse_tick();
        checks++; if (field !== 2'd3) begin errors++; $display("[TB] FAIL timeout_early: got %0d expected 3", field); end
        pulse_tick();
        checks++; if (field !== 2'd0) begin errors++; $display("[TB] FAIL timeout_field: got %0d expected 0", field); end
        checks++; if (edit_active !== 1'b0) begin errors++; $display("[TB] FAIL timeout_active: got %b expected 0", edit_active); end
        for (int k = 0; k < 3; k++) drive_press(0, 30, 30, st);
        pulse_tick();
        pulse_tick();
        change_with_tick();
        checks++; if (field !== 2'd0) begin errors++; $display("[TB] FAIL timeout_wrap: got %0d expected 0", field); end
        drive_press(0, 30, 30, st);
        pulse_tick();
        pulse_tick();
        change_with_tick();
        checks++; if (field !== 2'd2) begin errors++; $display("[TB] FAIL timeout_priority: got %0d expected 2", field); end
        pulse_tick();
        pulse_tick();
        checks++; if (field !== 2'd2) begin errors++; $display("[TB] FAIL timeout_restart: got %0d expected 2", field); end
        pulse_tick();
        checks++; if (field !== 2'd0) begin errors++; $display("[TB] FAIL timeout_after_priority: got %0d expected 0", field); end
    endtask

    task automatic test_both_buttons();
        int st;
        int d;
        drive_press(0, 30, 30, st);
        inc_q.delete();
        dec_q.delete();
        butt_increase = 1'b0;
        butt_decrease = 1'b0;
        repeat (40 + $urandom_range(0, 20)) @(negedge clk);
        checks++; if (inc_q.size() + dec_q.size() != 0) begin errors++; $display("[TB] FAIL both_held: got %0d expected 0", inc_q.size() + dec_q.size()); end
        butt_decrease = 1'b1;
        d = cyc;
        repeat (10) @(negedge clk);
        butt_increase = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (inc_q.size() != 1) begin
            errors++; $display("[TB] FAIL both_release_count: got %0d expected 1", inc_q.size());
        end else begin
            checks++; if (inc_q[0] != d + LAT) begin errors++; $display("[TB] FAIL both_release_time: got %0d expected %0d", inc_q[0], d + LAT); end
        end
        checks++; if (dec_q.size() != 0) begin errors++; $display("[TB] FAIL both_no_dec: got %0d expected 0", dec_q.size()); end
    endtask

    task automatic test_mode_and_reset();
        int st;
        drive_press(0, 30, 30, st);
        checks++; if (field !== 2'd2) begin errors++; $display("[TB] FAIL mode_setup: got %0d expected 2", field); end
        sw_mode = ~sw_mode;
        @(negedge clk);
        checks++; if (field !== 2'd0) begin errors++; $display("[TB] FAIL mode_abort: got %0d expected 0", field); end
        repeat (5) @(negedge clk);
        sw_mode = ~sw_mode;
        repeat (5) @(negedge clk);
        checks++; if (field !== 2'd0) begin errors++; $display("[TB] FAIL mode_run_toggle: got %0d expected 0", field); end
        drive_press(0, 30, 30, st);
        inc_q.delete();
        butt_increase = 1'b0;
        st = cyc;
        repeat (LAT + 3) @(negedge clk);
        checks++; if (inc_q.size() != 1 || inc_q[0] != st + LAT) begin errors++; $display("[TB] FAIL pre_reset_pulse: got %0d pulses expected 1 at %0d", inc_q.size(), st + LAT); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if ({field, led_field, edit_active, inc_pulse, dec_pulse} !== 8'd0) begin errors++; $display("[TB] FAIL midhold_reset: got %b expected 0", {field, led_field, edit_active, inc_pulse, dec_pulse}); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        inc_q.delete();
        repeat (20) @(negedge clk);
        drive_press(0, 30, 30, st);
        checks++; if (field !== 2'd1) begin errors++; $display("[TB] FAIL reenter_field: got %0d expected 1", field); end
        checks++; if (inc_q.size() != 0) begin errors++; $display("[TB] FAIL held_after_reset: got %0d expected 0", inc_q.size()); end
        butt_increase = 1'b1;
        repeat (20) @(negedge clk);
        drive_press(1, 12, 30, st);
        checks++;
        if (inc_q.size() != 1) begin
            errors++; $display("[TB] FAIL fresh_press_count: got %0d expected 1", inc_q.size());
        end else begin
            checks++; if (inc_q[0] != st + LAT) begin errors++; $display("[TB] FAIL fresh_press_time: got %0d expected %0d", inc_q[0], st + LAT); end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        tick_1s       = 1'b0;
        sw_mode       = 1'b0;
        butt_change   = 1'b1;
        butt_increase = 1'b1;
        butt_decrease = 1'b1;
        @(negedge clk);
        test_reset();
        test_change_cycle();
        test_glitch_and_press();
        test_repeat();
        test_timeout();
        test_both_buttons();
        test_mode_and_reset();
        checks++; if (both_err != 0) begin errors++; $display("[TB] FAIL both_strobes: got %0d expected 0", both_err); end
        checks++; if (run_err != 0) begin errors++; $display("[TB] FAIL run_strobes: got %0d expected 0", run_err); end
        checks++; if (led_err != 0) begin errors++; $display("[TB] FAIL led_decode: got %0d expected 0", led_err); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
